// File: rtl/ctrl_pipe_decoder.sv
// ctrl_pipe_decoder: decodes the ID opcode and carries the control bundle through ID/EX, EX/MEM and MEM/WB.
// Latency: ex_* 1 cycle, mem_* 2 cycles, wb_* 3 cycles after the opcode is presented in ID.
// Backpressure: hold freezes all stages; flush_e bubbles ID/EX even under hold. CTRL_ILLEGAL_CNT_EN builds illegal_cnt.
module ctrl_pipe_decoder #(
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [5:0]         id_op,
    input  logic               id_valid,
    input  logic               flush_e,
    input  logic               hold,
    output logic               ex_regdst,
    output logic               ex_alusrc,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic               ex_branch,
    output logic               ex_bne,
    output logic               ex_jump,
    output logic               ex_link,
    output logic               ex_illegal,
    output logic               mem_regwrite,
    output logic               mem_memwrite,
    output logic               mem_memtoreg,
    output logic               wb_regwrite,
    output logic               wb_memtoreg,
    output logic [CNT_W-1:0]   illegal_cnt
);

    typedef struct packed {
        logic               regwrite;
        logic               regdst;
        logic               alusrc;
        logic               branch;
        logic               bne;
        logic               memwrite;
        logic               memtoreg;
        logic               jump;
        logic               link;
        logic [ALUOP_W-1:0] aluop;
    } ctrl_t;

    ctrl_t w_dec;
    logic  w_illegal;

    always_comb begin
        w_dec     = '0;
        w_illegal = 1'b0;
        case (id_op)
            6'b000000: begin w_dec.regwrite = 1'b1; w_dec.regdst = 1'b1; w_dec.aluop = ALUOP_W'(3'b010); end
            6'b100011: begin w_dec.regwrite = 1'b1; w_dec.alusrc = 1'b1; w_dec.memtoreg = 1'b1; end
            6'b101011: begin w_dec.alusrc = 1'b1; w_dec.memwrite = 1'b1; end
            6'b000100: begin w_dec.branch = 1'b1; w_dec.aluop = ALUOP_W'(3'b001); end
            6'b000101: begin w_dec.bne = 1'b1; w_dec.aluop = ALUOP_W'(3'b001); end
            6'b001000: begin w_dec.regwrite = 1'b1; w_dec.alusrc = 1'b1; end
            6'b001100: begin w_dec.regwrite = 1'b1; w_dec.alusrc = 1'b1; w_dec.aluop = ALUOP_W'(3'b011); end
            6'b001101: begin w_dec.regwrite = 1'b1; w_dec.alusrc = 1'b1; w_dec.aluop = ALUOP_W'(3'b100); end
            6'b001010: begin w_dec.regwrite = 1'b1; w_dec.alusrc = 1'b1; w_dec.aluop = ALUOP_W'(3'b101); end
            6'b000010: begin w_dec.jump = 1'b1; end
            6'b000011: begin w_dec.jump = 1'b1; w_dec.link = 1'b1; w_dec.regwrite = 1'b1; end
            default:   w_illegal = 1'b1;
        endcase
    end

    ctrl_t r_idex;
    logic  r_ex_illegal;
    logic  r_mem_regwrite, r_mem_memwrite, r_mem_memtoreg;
    logic  r_wb_regwrite, r_wb_memtoreg;

    // Flush wins over hold for ID/EX only; the later stages obey hold alone.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idex       <= '0;
            r_ex_illegal <= 1'b0;
        end else if (flush_e) begin
            r_idex       <= '0;
            r_ex_illegal <= 1'b0;
        end else if (!hold) begin
            r_idex       <= id_valid ? w_dec : '0;
            r_ex_illegal <= id_valid & w_illegal;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem_regwrite <= 1'b0;
            r_mem_memwrite <= 1'b0;
            r_mem_memtoreg <= 1'b0;
            r_wb_regwrite  <= 1'b0;
            r_wb_memtoreg  <= 1'b0;
        end else if (!hold) begin
            r_mem_regwrite <= r_idex.regwrite;
            r_mem_memwrite <= r_idex.memwrite;
            r_mem_memtoreg <= r_idex.memtoreg;
            r_wb_regwrite  <= r_mem_regwrite;
            r_wb_memtoreg  <= r_mem_memtoreg;
        end
    end

`ifdef CTRL_ILLEGAL_CNT_EN
    logic             w_ill_evt;
    logic [CNT_W-1:0] r_illegal_cnt;

    assign w_ill_evt = id_valid & ~flush_e & ~hold & w_illegal;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_illegal_cnt <= '0;
        else if (w_ill_evt && (r_illegal_cnt != {CNT_W{1'b1}}))
            r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
    end

    assign illegal_cnt = r_illegal_cnt;
`else
    assign illegal_cnt = '0;
`endif

    assign ex_regdst    = r_idex.regdst;
    assign ex_alusrc    = r_idex.alusrc;
    assign ex_aluop     = r_idex.aluop;
    assign ex_branch    = r_idex.branch;
    assign ex_bne       = r_idex.bne;
    assign ex_jump      = r_idex.jump;
    assign ex_link      = r_idex.link;
    assign ex_illegal   = r_ex_illegal;
    assign mem_regwrite = r_mem_regwrite;
    assign mem_memwrite = r_mem_memwrite;
    assign mem_memtoreg = r_mem_memtoreg;
    assign wb_regwrite  = r_wb_regwrite;
    assign wb_memtoreg  = r_wb_memtoreg;

endmodule

// File: tb/tb_ctrl_pipe_decoder.sv
// Bench for ctrl_pipe_decoder: opcode table, directed pipeline corner cases, then random traffic vs a stage-array model.
module tb_ctrl_pipe_decoder;
    localparam int ALUOP_W = 3;
    localparam int CNT_W   = 2;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic [5:0]         id_op = 6'd0;
    logic               id_valid = 1'b0;
    logic               flush_e = 1'b0;
    logic               hold = 1'b0;
    logic               ex_regdst, ex_alusrc, ex_branch, ex_bne, ex_jump, ex_link, ex_illegal;
    logic [ALUOP_W-1:0] ex_aluop;
    logic               mem_regwrite, mem_memwrite, mem_memtoreg, wb_regwrite, wb_memtoreg;
    logic [CNT_W-1:0]   illegal_cnt;

    ctrl_pipe_decoder #(.ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .id_op(id_op), .id_valid(id_valid),
        .flush_e(flush_e), .hold(hold),
        .ex_regdst(ex_regdst), .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop),
        .ex_branch(ex_branch), .ex_bne(ex_bne), .ex_jump(ex_jump), .ex_link(ex_link),
        .ex_illegal(ex_illegal), .mem_regwrite(mem_regwrite), .mem_memwrite(mem_memwrite),
        .mem_memtoreg(mem_memtoreg), .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg),
        .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    // Bundle bits: [11]regwrite [10]regdst [9]alusrc [8]branch [7]bne [6]memwrite [5]memtoreg [4]jump [3]link [2:0]aluop
    typedef struct {
        logic [5:0]  op;
        logic [11:0] bundle;
        logic        ill;
    } vec_t;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000,
                           OP_J = 6'b000010, OP_JAL = 6'b000011, OP_BAD = 6'b111111;

    vec_t        tbl[12];
    int          checks = 0;
    int          errors = 0;
    logic [11:0] m_ex, m_mem, m_wb;
    logic        m_ill;
    int          m_events;

    function automatic logic [12:0] ref_decode(input logic [5:0] op);
        for (int i = 0; i < 11; i++)
            if (tbl[i].op == op) return {1'b0, tbl[i].bundle};
        return {1'b1, 12'h000};
    endfunction

    function automatic logic [8:0] ex_view(input logic [11:0] b);
        return {b[10], b[9], b[8], b[7], b[4], b[3], b[2:0]};
    endfunction

    function automatic int exp_cnt();
`ifdef CTRL_ILLEGAL_CNT_EN
        return (m_events > 3) ? 3 : m_events;
`else
        return 0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] dut_ex();
        return {ex_regdst, ex_alusrc, ex_branch, ex_bne, ex_jump, ex_link, ex_aluop};
    endfunction

    task automatic model_reset();
        m_ex = '0; m_mem = '0; m_wb = '0; m_ill = 1'b0; m_events = 0;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_ex"}, 32'(dut_ex()), 32'(ex_view(m_ex)));
        check({tag, "_ex_illegal"}, 32'(ex_illegal), 32'(m_ill));
        check({tag, "_mem"}, 32'({mem_regwrite, mem_memwrite, mem_memtoreg}), 32'({m_mem[11], m_mem[6], m_mem[5]}));
        check({tag, "_wb"}, 32'({wb_regwrite, wb_memtoreg}), 32'({m_wb[11], m_wb[5]}));
        check({tag, "_cnt"}, 32'(illegal_cnt), 32'(exp_cnt()));
    endtask

    task automatic check_all_zero(input string name);
        check(name, 32'({dut_ex(), ex_illegal, mem_regwrite, mem_memwrite, mem_memtoreg,
                         wb_regwrite, wb_memtoreg, illegal_cnt}), 32'd0);
    endtask

    // Drive one ID cycle, advance the model by the pipeline rules, then compare 1 ns after the edge.
    task automatic step(input string tag, input logic [5:0] op, input logic v, input logic f, input logic h);
        logic [12:0] d;
        id_op = op; id_valid = v; flush_e = f; hold = h;
        @(posedge clk);
        d = ref_decode(op);
        if (!h) begin
            m_wb  = m_mem;
            m_mem = m_ex;
            m_ex  = (f || !v) ? 12'h000 : d[11:0];
            m_ill = v && !f && d[12];
            if (m_ill) m_events++;
        end else if (f) begin
            m_ex  = 12'h000;
            m_ill = 1'b0;
        end
        #1;
        check_model(tag);
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{OP_R,      12'b1100_0000_0010, 1'b0};
        tbl[1]  = '{OP_LW,     12'b1010_0010_0000, 1'b0};
        tbl[2]  = '{OP_SW,     12'b0010_0100_0000, 1'b0};
        tbl[3]  = '{OP_BEQ,    12'b0001_0000_0001, 1'b0};
        tbl[4]  = '{OP_BNE,    12'b0000_1000_0001, 1'b0};
        tbl[5]  = '{OP_ADDI,   12'b1010_0000_0000, 1'b0};
        tbl[6]  = '{6'b001100, 12'b1010_0000_0011, 1'b0};
        tbl[7]  = '{6'b001101, 12'b1010_0000_0100, 1'b0};
        tbl[8]  = '{6'b001010, 12'b1010_0000_0101, 1'b0};
        tbl[9]  = '{OP_J,      12'b0000_0001_0000, 1'b0};
        tbl[10] = '{OP_JAL,    12'b1000_0001_1000, 1'b0};
        tbl[11] = '{OP_BAD,    12'b0000_0000_0000, 1'b1};
        model_reset();

        #1;
        check_all_zero("reset_state");
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            step("tbl", tbl[i].op, 1'b1, 1'b0, 1'b0);
            check($sformatf("tbl%0d_ex", i), 32'(dut_ex()), 32'(ex_view(tbl[i].bundle)));
            check($sformatf("tbl%0d_ill", i), 32'(ex_illegal), 32'(tbl[i].ill));
        end

        step("lw", OP_LW, 1'b1, 1'b0, 1'b0);
        check("lw_ex_alusrc", 32'(ex_alusrc), 32'd1);
        check("lw_ex_aluop", 32'(ex_aluop), 32'd0);
        step("nop", 6'd0, 1'b0, 1'b0, 1'b0);
        check("lw_mem", 32'({mem_memtoreg, mem_regwrite}), 32'b11);
        step("nop", 6'd0, 1'b0, 1'b0, 1'b0);
        check("lw_wb", 32'({wb_regwrite, wb_memtoreg}), 32'b11);

        step("jal", OP_JAL, 1'b1, 1'b0, 1'b0);
        check("jal_ex", 32'({ex_jump, ex_link}), 32'b11);
        step("nop", 6'd0, 1'b0, 1'b0, 1'b0);
        step("nop", 6'd0, 1'b0, 1'b0, 1'b0);
        check("jal_wb_regwrite", 32'(wb_regwrite), 32'd1);

        step("bne", OP_BNE, 1'b1, 1'b0, 1'b0);
        check("bne_ex", 32'({ex_bne, ex_branch, ex_aluop}), 32'b10_001);

        step("swflush", OP_SW, 1'b1, 1'b1, 1'b0);
        check("swflush_ex", 32'(dut_ex()), 32'd0);
        step("nop", 6'd0, 1'b0, 1'b0, 1'b0);
        check("swflush_mem_memwrite", 32'(mem_memwrite), 32'd0);

        step("nop", 6'd0, 1'b0, 1'b0, 1'b0);
        step("lw2", OP_LW, 1'b1, 1'b0, 1'b0);
        step("addi", OP_ADDI, 1'b1, 1'b0, 1'b0);
        check("addi_ex_alusrc", 32'(ex_alusrc), 32'd1);
        step("holdflush", OP_ADDI, 1'b1, 1'b1, 1'b1);
        check("holdflush_ex", 32'(dut_ex()), 32'd0);
        check("holdflush_mem", 32'({mem_regwrite, mem_memwrite, mem_memtoreg}), 32'b101);
        check("holdflush_wb", 32'({wb_regwrite, wb_memtoreg}), 32'b00);
        step("afterhold", 6'd0, 1'b0, 1'b0, 1'b0);
        check("afterhold_mem", 32'({mem_regwrite, mem_memwrite, mem_memtoreg}), 32'b000);
        check("afterhold_wb", 32'({wb_regwrite, wb_memtoreg}), 32'b11);

        pulse_reset();
        step("ill1", OP_BAD, 1'b1, 1'b0, 1'b0);
        check("ill_pulse", 32'(ex_illegal), 32'd1);
        check("ill_ctrl", 32'(dut_ex()), 32'd0);
`ifdef CTRL_ILLEGAL_CNT_EN
        check("ill_cnt1", 32'(illegal_cnt), 32'd1);
`else
        check("ill_cnt1", 32'(illegal_cnt), 32'd0);
`endif
        step("ill_clear", OP_ADDI, 1'b1, 1'b0, 1'b0);
        check("ill_cleared", 32'(ex_illegal), 32'd0);
        for (int i = 0; i < 4; i++)
            step("illn", OP_BAD, 1'b1, 1'b0, 1'b0);
`ifdef CTRL_ILLEGAL_CNT_EN
        check("ill_cnt_sat", 32'(illegal_cnt), 32'd3);
`else
        check("ill_cnt_sat", 32'(illegal_cnt), 32'd0);
`endif

        step("lw3", OP_LW, 1'b1, 1'b0, 1'b0);
        step("nop", 6'd0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset_midstream");
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;

        for (int n = 0; n < 400; n++) begin
            logic [5:0] op;
            op = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : tbl[$urandom_range(0, 10)].op;
            step("rnd", op, ($urandom_range(0, 7) != 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
